// File: rtl/lp805x_syncfifo.sv
// Synchronous first-word-fall-through FIFO with level, almost-full/empty
// thresholds and sticky overflow/underflow flags.
module lp805x_syncfifo #(
   parameter int DATA_WIDTH = 40,
   parameter int ADDR_WIDTH = 2,
   parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 1,
   parameter int AEMPTY_LVL = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wput,
   output logic                  wrdy,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  rget,
   output logic                  rrdy,
   input  logic                  flush,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  afull,
   output logic                  aempty,
   output logic                  ovf,
   output logic                  udf
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  full, empty, we, rd;

   // The extra MSB on each pointer separates full from empty when the index bits match.
   assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                  (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign we    = wput & ~full;
   assign rd    = rget & ~empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         ovf_d  = 1'b0;
         udf_d  = 1'b0;
      end else begin
         if (we) wptr_d = wptr_q + 1'b1;
         if (rd) rptr_d = rptr_q + 1'b1;
         if (wput && full)  ovf_d = 1'b1;
         if (rget && empty) udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   // Storage carries no reset; a write lost to rst/flush never becomes visible.
   always_ff @(posedge clk) begin
      if (we && !rst && !flush) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= data_in;
   end

   assign wrdy     = ~full;
   assign rrdy     = ~empty;
   assign data_out = empty ? '0 : mem_q[rptr_q[ADDR_WIDTH-1:0]];
   assign level    = wptr_q - rptr_q;
   assign afull    = (int'(level) >= AFULL_LVL);
   assign aempty   = (int'(level) <= AEMPTY_LVL);
   assign ovf      = ovf_q;
   assign udf      = udf_q;

endmodule

// File: tb/tb_lp805x_syncfifo.sv
// Randomized + directed bench: a default FIFO and a 2-deep 8-bit FIFO share
// stimulus and are compared every cycle against queue-based reference models.
module tb_lp805x_syncfifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, wput, rget;
   logic [39:0] din;

   logic        wrdy0, rrdy0, afull0, aempty0, ovf0, udf0;
   logic [39:0] dout0;
   logic [2:0]  level0;
   logic        wrdy1, rrdy1, afull1, aempty1, ovf1, udf1;
   logic [7:0]  dout1;
   logic [1:0]  level1;

   lp805x_syncfifo dut0 (
      .clk(clk), .rst(rst), .data_in(din), .wput(wput), .wrdy(wrdy0),
      .data_out(dout0), .rget(rget), .rrdy(rrdy0), .flush(flush),
      .level(level0), .afull(afull0), .aempty(aempty0), .ovf(ovf0), .udf(udf0)
   );

   lp805x_syncfifo #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .data_in(din[7:0]), .wput(wput), .wrdy(wrdy1),
      .data_out(dout1), .rget(rget), .rrdy(rrdy1), .flush(flush),
      .level(level1), .afull(afull1), .aempty(aempty1), .ovf(ovf1), .udf(udf1)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   // Reference model: one queue per FIFO, plus sticky flags.
   logic [39:0] mq [2][$];
   bit          movf [2];
   bit          mudf [2];
   int          dep  [2] = '{4, 2};
   int          afl  [2] = '{3, 1};

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         logic [39:0] d;
         bit full, empty;
         d     = (k == 0) ? din : (din & 40'hFF);
         full  = (mq[k].size() == dep[k]);
         empty = (mq[k].size() == 0);
         if (rst || flush) begin
            mq[k].delete();
            movf[k] = 0;
            mudf[k] = 0;
         end else begin
            if (wput && full)  movf[k] = 1;
            if (rget && empty) mudf[k] = 1;
            if (rget && !empty) void'(mq[k].pop_front());
            if (wput && !full)  mq[k].push_back(d);
         end
      end
   endtask

   task automatic check_all();
      int n0, n1;
      n0 = mq[0].size();
      n1 = mq[1].size();
      chk("d0.level",  64'(level0),  64'(n0));
      chk("d0.wrdy",   64'(wrdy0),   64'(n0 != dep[0]));
      chk("d0.rrdy",   64'(rrdy0),   64'(n0 != 0));
      chk("d0.dout",   64'(dout0),   (n0 != 0) ? 64'(mq[0][0]) : 64'd0);
      chk("d0.afull",  64'(afull0),  64'(n0 >= afl[0]));
      chk("d0.aempty", 64'(aempty0), 64'(n0 <= 1));
      chk("d0.ovf",    64'(ovf0),    64'(movf[0]));
      chk("d0.udf",    64'(udf0),    64'(mudf[0]));
      chk("d1.level",  64'(level1),  64'(n1));
      chk("d1.wrdy",   64'(wrdy1),   64'(n1 != dep[1]));
      chk("d1.rrdy",   64'(rrdy1),   64'(n1 != 0));
      chk("d1.dout",   64'(dout1),   (n1 != 0) ? 64'(mq[1][0]) : 64'd0);
      chk("d1.afull",  64'(afull1),  64'(n1 >= afl[1]));
      chk("d1.aempty", 64'(aempty1), 64'(n1 <= 1));
      chk("d1.ovf",    64'(ovf1),    64'(movf[1]));
      chk("d1.udf",    64'(udf1),    64'(mudf[1]));
   endtask

   task automatic cyc(input bit r, input bit f, input bit w, input bit g, input logic [39:0] d);
      rst = r; flush = f; wput = w; rget = g; din = d;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wput = 1'b0; rget = 1'b0; din = '0;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // In-order fill to full, then drain.
      cyc(0, 0, 1, 0, 40'h11);
      cyc(0, 0, 1, 0, 40'h22);
      cyc(0, 0, 1, 0, 40'h33);
      chk("fill.afull3", 64'(afull0), 64'd1);
      cyc(0, 0, 1, 0, 40'h44);
      chk("fill.wrdy4", 64'(wrdy0), 64'd0);
      chk("fill.head",  64'(dout0), 64'h11);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
      chk("drain.dout", 64'(dout0), 64'd0);

      // Push against full with a simultaneous pop: push dropped, ovf set.
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 40'hA0 + 40'(i));
      cyc(0, 0, 1, 1, 40'hEE);
      chk("fullrw.level", 64'(level0), 64'd3);
      chk("fullrw.ovf",   64'(ovf0),   64'd1);

      // Steady push+pop across pointer wrap.
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 40'h100);
      cyc(0, 0, 1, 0, 40'h101);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 40'h200 + 40'(i));
      chk("wrap.level", 64'(level0), 64'd2);

      // Underflow then flush clears it.
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      chk("udf.set", 64'(udf0), 64'd1);
      cyc(0, 1, 0, 0, 0);
      chk("udf.clr", 64'(udf0), 64'd0);

      // Flush overrides a concurrent push.
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 40'h300 + 40'(i));
      cyc(0, 1, 1, 0, 40'h3FF);
      chk("flush.level", 64'(level0), 64'd0);

      // Reset while the small FIFO is full, then one push.
      cyc(0, 0, 1, 0, 40'h5A);
      cyc(0, 0, 1, 0, 40'h5B);
      chk("small.full", 64'(wrdy1), 64'd0);
      cyc(1, 0, 1, 0, 40'h77);
      cyc(0, 0, 1, 0, 40'hA5);
      chk("small.a5", 64'(dout1), 64'hA5);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bit r, f, w, g;
         r = ($urandom_range(63, 0) == 0);
         f = ($urandom_range(31, 0) == 0);
         w = ($urandom_range(9, 0) < 6);
         g = ($urandom_range(9, 0) < 5);
         cyc(r, f, w, g, {8'($urandom), 32'($urandom)});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
